// File: rtl/wired_pkg_queue.sv
// Decoupling queue between the frontend package output and backend rename: DEPTH two-wide
// entries, slot-0 compaction, empty-package drop, flush. Optional macro: WIRED_PKG_QUEUE_BYPASS_EN.
module wired_pkg_queue #(
    parameter int DEPTH = 4,
    parameter int PKG_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               in_mask_i,
    input  logic [2*PKG_W-1:0]       in_pkg_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [1:0]               out_mask_o,
    output logic [2*PKG_W-1:0]       out_pkg_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    // Handshakes: a transfer happens on a side only in a cycle where both valid and ready are
    // high; valid never waits on ready, and in_ready_o/out_valid_o come from stored state only
    // (except the optional empty-queue bypass, which forwards the input to the output).

    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic [1:0]           r_mask_mem [DEPTH];
    logic [2*PKG_W-1:0]   r_pkg_mem  [DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_enq;
    logic                 w_in_nz;
    logic                 w_bypass;
    logic                 w_bypass_take;
    logic                 w_deq;
    logic                 w_wr;
    logic                 w_rd;
    logic [AW-1:0]        w_widx;
    logic [AW-1:0]        w_ridx;
    logic [1:0]           w_norm_mask;
    logic [2*PKG_W-1:0]   w_norm_pkg;

    assign w_widx  = r_wptr[AW-1:0];
    assign w_ridx  = r_rptr[AW-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

    assign in_ready_o = !w_full;
    assign w_enq      = in_valid_i && in_ready_o;
    assign w_in_nz    = |in_mask_i;

    // A lone slot-1 instruction is moved to slot 0 so the backend only ever sees 01 or 11.
    always_comb begin
        w_norm_mask = in_mask_i;
        w_norm_pkg  = in_pkg_i;
        if (in_mask_i == 2'b10) begin
            w_norm_mask = 2'b01;
            w_norm_pkg  = {in_pkg_i[2*PKG_W-1:PKG_W], in_pkg_i[2*PKG_W-1:PKG_W]};
        end
    end

`ifdef WIRED_PKG_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && w_enq && w_in_nz && !flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        out_valid_o = !w_empty || w_bypass;
        out_mask_o  = 2'b00;
        out_pkg_o   = r_pkg_mem[w_ridx];
        if (w_bypass) begin
            out_mask_o = w_norm_mask;
            out_pkg_o  = w_norm_pkg;
        end else if (!w_empty) begin
            out_mask_o = r_mask_mem[w_ridx];
        end
    end

    assign w_deq         = out_valid_o && out_ready_i;
    assign w_bypass_take = w_bypass && out_ready_i;
    assign w_wr          = w_enq && w_in_nz && !w_bypass_take;
    assign w_rd          = w_deq && !w_bypass_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Entry storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr && !flush_i) begin
            r_mask_mem[w_widx] <= w_norm_mask;
            r_pkg_mem[w_widx]  <= w_norm_pkg;
        end
    end

    assign count_o = r_wptr - r_rptr;

    a_mask_legal: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_o |-> (out_mask_o == 2'b01 || out_mask_o == 2'b11));

    a_mask_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid_o |-> (out_mask_o == 2'b00));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_o <= ($clog2(DEPTH)+1)'(DEPTH));

`ifndef WIRED_PKG_QUEUE_BYPASS_EN
    a_valid_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_o && !out_ready_i && !flush_i) |=> out_valid_o);
`endif

endmodule

// File: tb/tb_wired_pkg_queue.sv
// Directed bench for wired_pkg_queue: fill/full/drain, compaction, empty drop, wrap, flush,
// bypass timing and asynchronous reset.
module tb_wired_pkg_queue;

    localparam int DEPTH = 4;
    localparam int PKG_W = 16;

    logic                   clk;
    logic                   rst_n;
    logic                   flush_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [1:0]             in_mask_i;
    logic [2*PKG_W-1:0]     in_pkg_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [1:0]             out_mask_o;
    logic [2*PKG_W-1:0]     out_pkg_o;
    logic [$clog2(DEPTH):0] count_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*PKG_W-1:0] exp_q[$];
    logic [2*PKG_W-1:0] v;

    wired_pkg_queue #(.DEPTH(DEPTH), .PKG_W(PKG_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_mask_i  (in_mask_i),
        .in_pkg_i   (in_pkg_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_mask_o (out_mask_o),
        .out_pkg_o  (out_pkg_o),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*PKG_W-1:0] mk(input int k);
        return {16'hA000 + 16'(k), 16'h5000 + 16'(k)};
    endfunction

    task automatic drive(input logic vld, input logic [1:0] m, input logic [2*PKG_W-1:0] p,
                         input logic rdy, input logic fl);
        in_valid_i  = vld;
        in_mask_i   = m;
        in_pkg_i    = p;
        out_ready_i = rdy;
        flush_i     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_mask", out_mask_o, 2'b00);
        chk("rst_in_ready", in_ready_o, 1);

        // Fill to full with out_ready low.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, mk(i), 1'b0, 1'b0);
            #1 chk("fill_ready", in_ready_o, 1);
            @(posedge clk);
            #1 chk("fill_count", count_o, i + 1);
        end
        chk("full_in_ready", in_ready_o, 0);
        @(negedge clk);
        drive(1'b1, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #1 chk("full_refuse_count", count_o, DEPTH);

        // Drain in order.
        out_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("drain_valid", out_valid_o, 1);
            chk("drain_mask", out_mask_o, 2'b11);
            chk("drain_pkg", out_pkg_o, mk(i));
            @(negedge clk);
        end
        #1;
        chk("drained_count", count_o, 0);
        chk("drained_valid", out_valid_o, 0);

        // Mask 10 compacts slot 1 into slot 0; mask 01 kept as-is.
        @(negedge clk);
        drive(1'b1, 2'b10, {16'hBEEF, 16'h1111}, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b01, {16'h2222, 16'hC0DE}, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        out_ready_i = 1'b1;
        #1;
        chk("m10_mask", out_mask_o, 2'b01);
        chk("m10_slot0", out_pkg_o[PKG_W-1:0], 16'hBEEF);
        chk("two_count", count_o, 2);
        @(negedge clk);
        #1;
        chk("m01_mask", out_mask_o, 2'b01);
        chk("m01_slot0", out_pkg_o[PKG_W-1:0], 16'hC0DE);
        @(negedge clk);
        idle();

        // Empty package is accepted but dropped.
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h1234_5678, 1'b0, 1'b0);
        #1 chk("m00_ready", in_ready_o, 1);
        @(negedge clk);
        idle();
        #1;
        chk("m00_count", count_o, 0);
        chk("m00_valid", out_valid_o, 0);
        chk("m00_mask", out_mask_o, 2'b00);

        // Steady state at count 2 with simultaneous enq/deq; pointers wrap.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, mk(16 + k), 1'b0, 1'b0);
            exp_q.push_back(mk(16 + k));
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, mk(32 + k), 1'b1, 1'b0);
            #1;
            chk("ss_count", count_o, 2);
            v = exp_q.pop_front();
            chk("ss_pkg", out_pkg_o, v);
            exp_q.push_back(mk(32 + k));
        end
        @(negedge clk);
        idle();
        out_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            v = exp_q.pop_front();
            chk("ss_tail_pkg", out_pkg_o, v);
            @(negedge clk);
        end
        idle();
        #1 chk("ss_end_count", count_o, 0);

        // Flush at count 3 together with enq and deq.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, mk(64 + k), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 2'b11, 32'hF1F1_F1F1, 1'b1, 1'b1);
        #1 chk("flush_in_ready", in_ready_o, 1);
        @(negedge clk);
        idle();
        #1;
        chk("flush_count", count_o, 0);
        chk("flush_valid", out_valid_o, 0);
        chk("flush_mask", out_mask_o, 2'b00);
        @(negedge clk);
        drive(1'b1, 2'b11, 32'h6060_6060, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("post_flush_count", count_o, 1);
        chk("post_flush_pkg", out_pkg_o, 32'h6060_6060);
        out_ready_i = 1'b1;
        @(negedge clk);
        idle();

        // Empty queue, ready backend: bypass vs registered path.
        @(negedge clk);
        drive(1'b1, 2'b11, 32'hB0B0_B1B1, 1'b1, 1'b0);
        #1;
`ifdef WIRED_PKG_QUEUE_BYPASS_EN
        chk("byp_same_valid", out_valid_o, 1);
        chk("byp_same_pkg", out_pkg_o, 32'hB0B0_B1B1);
        chk("byp_same_count", count_o, 0);
        @(negedge clk);
        drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
        #1;
        chk("byp_next_count", count_o, 0);
        chk("byp_next_valid", out_valid_o, 0);
`else
        chk("nobyp_same_valid", out_valid_o, 0);
        chk("nobyp_same_count", count_o, 0);
        @(negedge clk);
        drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
        #1;
        chk("nobyp_next_count", count_o, 1);
        chk("nobyp_next_valid", out_valid_o, 1);
        chk("nobyp_next_pkg", out_pkg_o, 32'hB0B0_B1B1);
        @(negedge clk);
        #1 chk("nobyp_after_count", count_o, 0);
`endif

        // Asynchronous reset in the middle of a cycle.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, mk(80 + k), 1'b0, 1'b0);
        end
        @(negedge clk);
        idle();
        #1 chk("pre_areset_count", count_o, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_count", count_o, 0);
        chk("areset_valid", out_valid_o, 0);
        chk("areset_ready", in_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
